// File: rtl/sistema_cpu_debug_pkg.sv
// Shared types and constants for the CPU debug command receiver.
package sistema_cpu_debug_pkg;

  localparam int SR_W_DEF = 38;
  localparam int IR_W_DEF = 2;

  // Handshake state toward the debug core
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cmd_state_e;

  // Instruction register codes
  localparam logic [IR_W_DEF-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [IR_W_DEF-1:0] IR_TRACECTRL = 2'd1;
  localparam logic [IR_W_DEF-1:0] IR_BREAK     = 2'd2;
  localparam logic [IR_W_DEF-1:0] IR_TRACEMEM  = 2'd3;

endpackage

// File: rtl/sistema_cpu_debug_sync_edge.sv
// Level synchroniser (SYNC_STAGES flops, legal 2..4) followed by a
// registered rising-edge detector. rise is a one-cycle pulse in clk.
module sistema_cpu_debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  // Shift the async level in; flag a 0->1 transition at the chain output
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Synchroniser and edge flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sistema_cpu_debug_cmd_sync.sv
// Sysclk-side JTAG debug command receiver: synchronises update-DR/IR
// events, decodes per-IR action/no-action strobes and keeps a
// pending/ack handshake. Define DEBUG_CMD_OVERRUN_EN to drop action
// commands that arrive while one is pending and count them as overruns;
// otherwise such commands overwrite the pending one.
module sistema_cpu_debug_cmd_sync
  import sistema_cpu_debug_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SR_W-1:0]      sr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic                 cmd_ack,
  input  logic                 overrun_clr,
  output logic [SR_W-1:0]      jdo,
  output logic [IR_W-1:0]      ir_q,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 cmd_pending,
  output logic                 overrun,
  output logic [7:0]           overrun_cnt
);

  localparam int NUM_CMD = 2**IR_W;

  // Index 0: update-DR, index 1: update-IR
  logic [1:0] rise;
  logic       udr_rise, uir_rise;

  sistema_cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({vs_uir, vs_udr}),
    .rise    (rise)
  );

  assign udr_rise = rise[0];
  assign uir_rise = rise[1];

  cmd_state_e         state_q, state_d;
  logic [SR_W-1:0]    jdo_q, jdo_d;
  logic [IR_W-1:0]    ir_cap_q, ir_cap_d;
  logic [NUM_CMD-1:0] ta_q, ta_d, tna_q, tna_d;
  logic [IR_W-1:0]    dec_ir;
  logic               act_cmd, noact_cmd, accept;

  // An IR update landing with the DR update must steer this command
  assign dec_ir    = uir_rise ? ir_in : ir_cap_q;
  assign act_cmd   = udr_rise &  sr[SR_W-1];
  assign noact_cmd = udr_rise & ~sr[SR_W-1];

`ifdef DEBUG_CMD_OVERRUN_EN
  logic       ovr_hit;
  logic       ovr_q, ovr_d;
  logic [7:0] ovr_cnt_q, ovr_cnt_d;
`endif

  // Command decode, strobe generation and handshake next-state
  always_comb begin
    state_d  = state_q;
    jdo_d    = jdo_q;
    ir_cap_d = ir_cap_q;
    ta_d     = '0;
    tna_d    = '0;
    accept   = 1'b0;
`ifdef DEBUG_CMD_OVERRUN_EN
    ovr_hit  = 1'b0;
`endif
    if (uir_rise) ir_cap_d = ir_in;
    if (noact_cmd) begin
      jdo_d         = sr;
      tna_d[dec_ir] = 1'b1;
    end
    unique case (state_q)
      IDLE: accept = act_cmd;
      PENDING: begin
        if (cmd_ack) state_d = IDLE;
        if (act_cmd) begin
`ifdef DEBUG_CMD_OVERRUN_EN
          if (cmd_ack) accept  = 1'b1;
          else         ovr_hit = 1'b1;
`else
          accept = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      jdo_d        = sr;
      ta_d[dec_ir] = 1'b1;
      state_d      = PENDING;
    end
  end

  // Command and handshake registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      jdo_q    <= '0;
      ir_cap_q <= '0;
      ta_q     <= '0;
      tna_q    <= '0;
    end else begin
      state_q  <= state_d;
      jdo_q    <= jdo_d;
      ir_cap_q <= ir_cap_d;
      ta_q     <= ta_d;
      tna_q    <= tna_d;
    end
  end

`ifdef DEBUG_CMD_OVERRUN_EN
  // Sticky overrun flag and saturating count; a new overrun beats a clear
  always_comb begin
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_clr) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = 8'd0;
    end
    if (ovr_hit) begin
      ovr_d     = 1'b1;
      ovr_cnt_d = overrun_clr ? 8'd1 :
                  (ovr_cnt_q == 8'hFF) ? 8'hFF : ovr_cnt_q + 8'd1;
    end
  end

  // Overrun registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= 8'd0;
    end else begin
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun     = ovr_q;
  assign overrun_cnt = ovr_cnt_q;
`else
  logic ovr_clr_unused;
  assign ovr_clr_unused = overrun_clr;
  assign overrun        = 1'b0;
  assign overrun_cnt    = 8'd0;
`endif

  assign jdo            = jdo_q;
  assign ir_q           = ir_cap_q;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign cmd_pending    = (state_q == PENDING);

endmodule

// File: tb/tb_sistema_cpu_debug_cmd_sync.sv
// Randomised + directed bench for sistema_cpu_debug_cmd_sync against a
// transaction-level model. Honours DEBUG_CMD_OVERRUN_EN like the RTL.
module tb_sistema_cpu_debug_cmd_sync;

  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int N    = 2;
  localparam int NC   = 4;
`ifdef DEBUG_CMD_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic            clk = 1'b0, reset_n = 1'b0;
  logic [SR_W-1:0] sr = '0;
  logic [IR_W-1:0] ir_in = '0;
  logic            vs_udr = 1'b0, vs_uir = 1'b0, cmd_ack = 1'b0, overrun_clr = 1'b0;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] ir_q;
  logic [NC-1:0]   take_action, take_no_action;
  logic            cmd_pending, overrun;
  logic [7:0]      overrun_cnt;

  always #5 clk = ~clk;

  sistema_cpu_debug_cmd_sync #(.SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(N)) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ack(cmd_ack), .overrun_clr(overrun_clr),
    .jdo(jdo), .ir_q(ir_q), .take_action(take_action), .take_no_action(take_no_action),
    .cmd_pending(cmd_pending), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  int n_chk = 0, n_fail = 0;

  // Model state
  bit              m_pend = 1'b0, m_ovr = 1'b0;
  logic [SR_W-1:0] m_jdo = '0;
  logic [IR_W-1:0] m_ir = '0;
  int              m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({jdo, ir_q, take_action, take_no_action, cmd_pending, overrun, overrun_cnt});
  endfunction

  function automatic logic [SR_W-1:0] rnd_sr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[SR_W-1:0];
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".jdo"},  64'(jdo),         64'(m_jdo));
    chk({tag, ".pend"}, 64'(cmd_pending), 64'(m_pend));
    chk({tag, ".ovr"},  64'(overrun),     64'(m_ovr));
    chk({tag, ".cnt"},  64'(overrun_cnt), 64'(m_cnt));
    chk({tag, ".ir"},   64'(ir_q),        64'(m_ir));
  endtask

  task automatic set_ir(input logic [IR_W-1:0] v);
    ir_in = v; vs_uir = 1'b1;
    tick(N + 2);
    vs_uir = 1'b0;
    tick(N + 2);
    m_ir = v;
    chk("ir_q", 64'(ir_q), 64'(v));
  endtask

  // One update-DR event; ack_same drives cmd_ack in the udr_rise cycle
  task automatic cmd(input logic [SR_W-1:0] s, input bit ack_same);
    logic [NC-1:0] e_ta, e_tna;
    e_ta = '0; e_tna = '0;
    if (!s[SR_W-1]) begin
      m_jdo = s; e_tna[m_ir] = 1'b1;
      if (ack_same) m_pend = 1'b0;
    end else if (!m_pend || ack_same || !OVR_EN) begin
      m_jdo = s; e_ta[m_ir] = 1'b1; m_pend = 1'b1;
    end else begin
      m_ovr = 1'b1;
      m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    end
    sr = s; vs_udr = 1'b1;
    tick(N + 1);
    chk("pre_strobe", 64'({take_action, take_no_action}), 64'd0);
    cmd_ack = ack_same;
    tick(1);
    cmd_ack = 1'b0;
    chk("take_action",    64'(take_action),    64'(e_ta));
    chk("take_no_action", 64'(take_no_action), 64'(e_tna));
    check_state("cmd");
    tick(1);
    chk("strobe_1cyc", 64'({take_action, take_no_action}), 64'd0);
    tick(N);
    vs_udr = 1'b0;
    tick(N + 2);
  endtask

  task automatic ack();
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    m_pend = 1'b0;
    chk("ack_pend", 64'(cmd_pending), 64'd0);
  endtask

  task automatic clr();
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    m_ovr = 1'b0; m_cnt = 0;
    chk("clr_ovr", 64'({overrun, overrun_cnt}), 64'd0);
  endtask

  function automatic logic [SR_W-1:0] act_sr();
    logic [SR_W-1:0] s;
    s = rnd_sr();
    s[SR_W-1] = 1'b1;
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    reset_n = 1'b1;
    repeat (20) begin
      tick(1);
      chk("rst_idle", all_out(), 64'd0);
    end

    // Action command with IR=BREAK, then ack
    set_ir(2'd2);
    cmd(38'h20_1234_5678, 1'b0);
    ack();

    // No-action command with IR=TRACECTRL
    set_ir(2'd1);
    cmd(38'h0_dead_beef, 1'b0);

    // Two action commands without ack
    set_ir(2'd3);
    cmd(38'h3F_0000_0001, 1'b0);
    cmd(38'h2A_5555_AAAA, 1'b0);
`ifdef DEBUG_CMD_OVERRUN_EN
    repeat (300) cmd(act_sr(), 1'b0);
    chk("ovr_sat", 64'(overrun_cnt), 64'd255);
`endif
    clr();
    ack();

    // Ack coinciding with a new command
    cmd(act_sr(), 1'b0);
    cmd(act_sr(), 1'b1);
    chk("ack_same_pend", 64'(cmd_pending), 64'd1);
    chk("ack_same_ovr",  64'(overrun),     64'd0);
    ack();

    // Reset between sampling and strobe
    sr = 38'h25_0000_00AA; vs_udr = 1'b1;
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("rst_mid", all_out(), 64'd0);
    vs_udr = 1'b0;
    tick(3);
    chk("rst_hold", all_out(), 64'd0);
    reset_n = 1'b1;
    m_pend = 1'b0; m_ovr = 1'b0; m_cnt = 0; m_jdo = '0; m_ir = '0;
    repeat (6) begin
      tick(1);
      chk("post_rst", all_out(), 64'd0);
    end
    set_ir(2'd2);
    cmd(act_sr(), 1'b0);
    ack();

    // Random mix
    repeat (80) begin
      case ($urandom_range(0, 5))
        0:       set_ir(IR_W'($urandom_range(0, NC - 1)));
        1, 2, 3: cmd(rnd_sr(), 1'($urandom_range(0, 1)));
        4:       ack();
        default: clr();
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
